// File: rtl/alu.sv
// Registered two-operand ALU: ADD/SUB/MUL/PASS with a zero flag.
// One-cycle latency; result and flag are registered on the same edge.
module alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [1:0]   alu_op,
    output logic [N-1:0] alu_out,
    output logic         z
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_t;

    logic [N-1:0] alu_out_d, alu_out_q;
    logic         z_d, z_q;

    // Low N bits of a product are the same for signed and unsigned operands,
    // so a plain N-bit multiply gives the wrapped signed result.
    always_comb begin
        alu_out_d = '0;
        unique case (alu_op_t'(alu_op))
            OP_ADD:  alu_out_d = in1 + in2;
            OP_SUB:  alu_out_d = in1 - in2;
            OP_MUL:  alu_out_d = in1 * in2;
            OP_PASS: alu_out_d = in1;
            default: alu_out_d = '0;
        endcase
        z_d = (alu_out_d == '0);
    end

    // Reset branch assigns constants only, so X on the inputs cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            z_q       <= 1'b1;
        end else begin
            alu_out_q <= alu_out_d;
            z_q       <= z_d;
        end
    end

    assign alu_out = alu_out_q;
    assign z       = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU (N = 8).
// Drives inputs between edges and checks outputs 1 time unit after each rising edge.
module tb_alu;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_out;
    logic         z;

    int num_checks;
    int num_fails;

    alu #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .in1     (in1),
        .in2     (in2),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [N-1:0] observed,
                            input logic [N-1:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Apply one transaction, let one rising edge register it, then check both outputs.
    task automatic step(input string tag, input logic r, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [1:0] op,
                        input logic [N-1:0] exp_out, input logic exp_z);
        rst    = r;
        in1    = a;
        in2    = b;
        alu_op = op;
        @(posedge clk);
        #1;
        check_eq({tag, ".out"}, alu_out, exp_out);
        check_eq({tag, ".z"}, {{(N-1){1'b0}}, z}, {{(N-1){1'b0}}, exp_z});
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        rst    = 1'b1;
        in1    = 'x;
        in2    = 'x;
        alu_op = 'x;

        // Reset for two cycles with X inputs
        step("reset0", 1'b1, 'x, 'x, 'x, 8'h00, 1'b1);
        step("reset1", 1'b1, 'x, 'x, 'x, 8'h00, 1'b1);

        // ADD
        step("add_5_10",  1'b0, 8'd5,  8'd10, 2'b00, 8'h0F, 1'b0);
        step("add_30_10", 1'b0, 8'd30, 8'd10, 2'b00, 8'h28, 1'b0);

        // SUB held for three cycles
        for (int i = 0; i < 3; i++)
            step($sformatf("sub_5_10_c%0d", i), 1'b0, 8'd5, 8'd10, 2'b01, 8'hFB, 1'b0);

        // MUL
        step("mul_4_20",  1'b0, 8'd4,  8'd20, 2'b10, 8'h50, 1'b0);
        step("mul_m3_5",  1'b0, 8'hFD, 8'd5,  2'b10, 8'hF1, 1'b0);

        // Boundaries
        step("add_127_1",     1'b0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b0);
        step("sub_10_10",     1'b0, 8'd10, 8'd10, 2'b01, 8'h00, 1'b1);
        step("mul_m128_m1",   1'b0, 8'h80, 8'hFF, 2'b10, 8'h80, 1'b0);
        step("pass_5a",       1'b0, 8'h5A, 8'h33, 2'b11, 8'h5A, 1'b0);
        step("pass_zero",     1'b0, 8'h00, 8'hFF, 2'b11, 8'h00, 1'b1);
        step("add_wrap_zero", 1'b0, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
        step("mul_hi_bits",   1'b0, 8'h10, 8'h10, 2'b10, 8'h00, 1'b1);

        // Back-to-back opcode changes with a one-cycle reset pulse
        step("b2b_add",   1'b0, 8'd1,  8'd2,  2'b00, 8'h03, 1'b0);
        step("b2b_rst",   1'b1, 8'd9,  8'd4,  2'b01, 8'h00, 1'b1);
        step("b2b_mul",   1'b0, 8'd3,  8'd3,  2'b10, 8'h09, 1'b0);
        step("b2b_pass",  1'b0, 8'h11, 8'd0,  2'b11, 8'h11, 1'b0);
        step("b2b_sub",   1'b0, 8'd0,  8'd1,  2'b01, 8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
